// File: rtl/fp32_acc.sv
// fp32_acc: multi-cycle IEEE-754 single-precision accumulator.
// Accepts one FP32 addend per handshake and adds it to a running sum with
// round-to-nearest-even. The sum is presented after the element tagged last.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_data / in_last valid
//   in_ready  out  block can accept an element (IDLE only)
//   in_data   in   FP32 addend
//   in_last   in   final element of the current dot product
//   out_valid out  out_data holds a completed sum
//   out_ready in   consumer accepts out_data
//   out_data  out  FP32 accumulated sum
//
// Pipeline per element: IDLE (accept) -> ALIGN -> ADD -> NORM -> IDLE/OUT.
// NaN/Inf cases are resolved in ALIGN and bypass ADD.
module fp32_acc #(
    parameter logic [31:0] ACC_INIT = 32'h0000_0000,
    parameter int unsigned GRS_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    // Aligned significand width: hidden bit + 23 fraction bits + guard/round/sticky.
    localparam int unsigned MW = 24 + GRS_BITS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Leading-zero count of an aligned significand; MW when it is all zero.
    function automatic logic [4:0] lzc(input logic [MW-1:0] v);
        logic [4:0] n;
        n = 5'(MW);
        for (int i = 0; i < int'(MW); i++) begin
            if (v[i]) begin
                n = 5'(int'(MW) - 1 - i);
            end
        end
        return n;
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic          in_ready_r;
    logic          out_valid_r;
    logic [31:0]   acc_r;
    logic [31:0]   op_r;
    logic          last_r;

    // ALIGN stage results
    logic          special_r;
    logic [31:0]   special_val_r;
    logic          a_sign_r;
    logic          b_sign_r;
    logic [9:0]    a_exp_r;
    logic [MW-1:0] a_mant_r;
    logic [MW-1:0] b_mant_r;
    logic          both_neg_zero_r;

    // ADD stage results
    logic [MW:0]   sum_r;
    logic          sum_sign_r;

    // ALIGN combinational signals
    logic          acc_nan_s, op_nan_s, acc_inf_s, op_inf_s;
    logic          special_s;
    logic [31:0]   special_val_s;
    logic          swap_s;
    logic [31:0]   big_s, small_s;
    logic [7:0]    big_exp_s, small_exp_s, diff_s;
    logic [MW-1:0] big_mant_s, small_mant_s, shifted_s, b_al_s;
    logic          lost_s;

    // ADD combinational signals
    logic [MW:0]   sum_s;
    logic          sum_sign_s;

    // NORM combinational signals
    logic [4:0]    lz_s;
    logic [9:0]    lim_s, sh_s, norm_e_s, exp_f_s;
    logic [MW-1:0] norm_m_s;
    logic [23:0]   frac_s;
    logic          rnd_up_s;
    logic [24:0]   rounded_s;
    logic [22:0]   man_f_s;
    logic [31:0]   norm_res_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;

    // Next-state logic for the accumulate sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ALIGN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ALIGN: begin
                if (special_s) begin
                    state_nxt_s = NORM;
                end else begin
                    state_nxt_s = ADD;
                end
            end
            ADD: state_nxt_s = NORM;
            NORM: begin
                if (last_r) begin
                    state_nxt_s = OUT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Unpack, special-case detection, magnitude swap and alignment shift.
    always_comb begin
        acc_nan_s     = (acc_r[30:23] == 8'hFF) && (acc_r[22:0] != 23'h0);
        op_nan_s      = (op_r[30:23] == 8'hFF) && (op_r[22:0] != 23'h0);
        acc_inf_s     = (acc_r[30:23] == 8'hFF) && (acc_r[22:0] == 23'h0);
        op_inf_s      = (op_r[30:23] == 8'hFF) && (op_r[22:0] == 23'h0);
        special_s     = 1'b0;
        special_val_s = 32'h0000_0000;
        if (acc_nan_s || op_nan_s || (acc_inf_s && op_inf_s && (acc_r[31] != op_r[31]))) begin
            special_s     = 1'b1;
            special_val_s = 32'hFFC0_0000;
        end else if (acc_inf_s) begin
            special_s     = 1'b1;
            special_val_s = acc_r;
        end else if (op_inf_s) begin
            special_s     = 1'b1;
            special_val_s = op_r;
        end else begin
            special_s     = 1'b0;
            special_val_s = 32'h0000_0000;
        end

        // Magnitude compare on exponent:fraction picks operand A.
        swap_s  = (op_r[30:0] > acc_r[30:0]);
        big_s   = swap_s ? op_r : acc_r;
        small_s = swap_s ? acc_r : op_r;

        // Subnormals behave as exponent field 1 with a zero hidden bit.
        big_exp_s    = (big_s[30:23] == 8'h00) ? 8'd1 : big_s[30:23];
        small_exp_s  = (small_s[30:23] == 8'h00) ? 8'd1 : small_s[30:23];
        big_mant_s   = {(big_s[30:23] != 8'h00), big_s[22:0], {GRS_BITS{1'b0}}};
        small_mant_s = {(small_s[30:23] != 8'h00), small_s[22:0], {GRS_BITS{1'b0}}};
        diff_s       = big_exp_s - small_exp_s;

        shifted_s = {MW{1'b0}};
        lost_s    = 1'b0;
        if (diff_s >= 8'(MW)) begin
            b_al_s = {{(MW-1){1'b0}}, |small_mant_s};
        end else begin
            shifted_s = small_mant_s >> diff_s;
            lost_s    = |(small_mant_s & ~({MW{1'b1}} << diff_s));
            b_al_s    = {shifted_s[MW-1:1], shifted_s[0] | lost_s};
        end
    end

    // Signed-magnitude add; A is never smaller than B so the difference is non-negative.
    always_comb begin
        if (a_sign_r == b_sign_r) begin
            sum_s = {1'b0, a_mant_r} + {1'b0, b_mant_r};
        end else begin
            sum_s = {1'b0, a_mant_r} - {1'b0, b_mant_r};
        end
        if (sum_s == {(MW+1){1'b0}}) begin
            sum_sign_s = both_neg_zero_r;
        end else begin
            sum_sign_s = a_sign_r;
        end
    end

    // Normalize, round to nearest even and pack the result.
    always_comb begin
        lz_s  = lzc(sum_r[MW-1:0]);
        lim_s = a_exp_r - 10'd1;
        sh_s  = 10'd0;
        if (sum_r[MW]) begin
            norm_m_s = {sum_r[MW:2], sum_r[1] | sum_r[0]};
            norm_e_s = a_exp_r + 10'd1;
        end else begin
            // Clamp so the exponent stops at the subnormal boundary.
            sh_s     = ({5'd0, lz_s} > lim_s) ? lim_s : {5'd0, lz_s};
            norm_m_s = sum_r[MW-1:0] << sh_s;
            norm_e_s = a_exp_r - sh_s;
        end

        frac_s    = norm_m_s[MW-1:GRS_BITS];
        rnd_up_s  = norm_m_s[2] & (norm_m_s[1] | norm_m_s[0] | frac_s[0]);
        rounded_s = {1'b0, frac_s} + {24'd0, rnd_up_s};

        // Rounding carry renormalizes; a missing hidden bit means subnormal.
        if (rounded_s[24]) begin
            exp_f_s = norm_e_s + 10'd1;
            man_f_s = rounded_s[23:1];
        end else if (rounded_s[23]) begin
            exp_f_s = norm_e_s;
            man_f_s = rounded_s[22:0];
        end else begin
            exp_f_s = 10'd0;
            man_f_s = rounded_s[22:0];
        end

        if (special_r) begin
            norm_res_s = special_val_r;
        end else if (exp_f_s >= 10'd255) begin
            norm_res_s = {sum_sign_r, 8'hFF, 23'h0};
        end else begin
            norm_res_s = {sum_sign_r, exp_f_s[7:0], man_f_s};
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == OUT);
        end
    end

    // Capture the accepted element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= 32'h0000_0000;
            last_r <= 1'b0;
        end else if ((state_r == IDLE) && in_valid) begin
            op_r   <= in_data;
            last_r <= in_last;
        end else begin
            op_r   <= op_r;
            last_r <= last_r;
        end
    end

    // ALIGN stage pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_r       <= 1'b0;
            special_val_r   <= 32'h0000_0000;
            a_sign_r        <= 1'b0;
            b_sign_r        <= 1'b0;
            a_exp_r         <= 10'd0;
            a_mant_r        <= {MW{1'b0}};
            b_mant_r        <= {MW{1'b0}};
            both_neg_zero_r <= 1'b0;
        end else if (state_r == ALIGN) begin
            special_r       <= special_s;
            special_val_r   <= special_val_s;
            a_sign_r        <= big_s[31];
            b_sign_r        <= small_s[31];
            a_exp_r         <= {2'b00, big_exp_s};
            a_mant_r        <= big_mant_s;
            b_mant_r        <= b_al_s;
            both_neg_zero_r <= (acc_r == 32'h8000_0000) && (op_r == 32'h8000_0000);
        end else begin
            special_r       <= special_r;
            special_val_r   <= special_val_r;
            a_sign_r        <= a_sign_r;
            b_sign_r        <= b_sign_r;
            a_exp_r         <= a_exp_r;
            a_mant_r        <= a_mant_r;
            b_mant_r        <= b_mant_r;
            both_neg_zero_r <= both_neg_zero_r;
        end
    end

    // ADD stage pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= {(MW+1){1'b0}};
            sum_sign_r <= 1'b0;
        end else if (state_r == ADD) begin
            sum_r      <= sum_s;
            sum_sign_r <= sum_sign_s;
        end else begin
            sum_r      <= sum_r;
            sum_sign_r <= sum_sign_r;
        end
    end

    // Accumulator: written in NORM, cleared on the result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= ACC_INIT;
        end else if (state_r == NORM) begin
            acc_r <= norm_res_s;
        end else if ((state_r == OUT) && out_ready) begin
            acc_r <= ACC_INIT;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: doc/fp32_acc.md
Name: fp32_acc

Overview:
- Multi-cycle FP32 accumulator that sits directly downstream of the FP32 multiplier in each processing element.
- Consumes the stream of IEEE-754 single-precision products over a valid/ready handshake and sums them into a running accumulator with round-to-nearest-even.
- Presents the dot-product result on a second valid/ready port when the element tagged last has been added.

Parameters:
- ACC_INIT, 32'h00000000, accumulator value after reset and after each result handshake.
- GRS_BITS, 3, extra alignment bits below the 24-bit significand (guard, round, sticky); fixed at 3, others unsupported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept an element.
- in_data  input  32  FP32 addend (multiplier product).
- in_last  input  1  final element of the current dot product.
- out_valid  output  1  out_data holds a completed sum.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  FP32 accumulated sum.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, acc=ACC_INIT.
  - Outputs: in_ready=1, out_valid=0, out_data=ACC_INIT.
  - Reset asserted mid-operation abandons the element in flight and the partial sum; there is no output handshake for it.
- States: IDLE, ALIGN, ADD, NORM, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register in_data and in_last, then go to ALIGN.
  - in_ready=0 in every other state.
- ALIGN:
  - Unpack acc and the operand. Subnormals use exponent -126 and a hidden bit of 0.
  - Handle specials here; they skip ADD and go directly to NORM with the result fixed:
    - Any NaN input gives 32'hFFC00000.
    - +Inf + -Inf gives 32'hFFC00000.
    - One Inf gives that Inf.
  - Otherwise swap so the larger-magnitude operand is A.
  - Right-shift B by the exponent difference into 27 bits (24 + GRS). Bits shifted out OR into sticky. A shift of 27 or more leaves sticky only.
- ADD:
  - Equal signs: 28-bit add. Different signs: A-B.
  - Result sign = sign of A.
  - Exact zero result: +0, unless both operands were -0, which gives -0.
- NORM (normalize and round in one cycle):
  - On carry-out, right-shift by 1 and increment the exponent. Otherwise left-shift by the leading-zero count, clamped so the exponent never drops below -126; the result is subnormal when clamped.
  - Round RNE on G/R/S. A rounding carry renormalizes.
  - Biased exponent >= 255 gives signed Inf, 0x7F800000 or 0xFF800000.
  - Write acc. If the registered last bit is set go to OUT, else go to IDLE.
- OUT:
  - out_valid=1, out_data=acc.
  - Hold out_data stable while out_valid=1 and out_ready=0.
  - On out_ready: acc=ACC_INIT, out_valid=0, go to IDLE.
- Timing:
  - Element accepted in cycle C0. ALIGN in C1, ADD in C2, NORM in C3.
  - C4: in_ready=1 (IDLE) or out_valid=1 (OUT).
  - Throughput: one element per 4 cycles. Result latency: 4 cycles after the last accept.
- Rules:
  - NaN is sticky: once acc is NaN, further adds keep 32'hFFC00000 until the result handshake.
  - in_data may change freely while in_ready=0; it is ignored.
  - out_valid and in_ready are never both 1.

Test Plan:
- Reset then accept 32'h3F800000 (1.0, last=0), then 32'h40000000 (2.0, last=1) -> out_valid rises 4 cycles after the second accept with out_data=32'h40400000; in_ready=0 during C1-C3.
- Single element 32'h3F800000 with last=1, then out_ready held 0 for 5 cycles -> out_data=32'h3F800000 stable, out_valid=1, in_ready=0; after handshake the next single 32'h40000000 yields 32'h40000000 (acc cleared).
- 32'h3F800000 then 32'hBF800000 (last) -> 32'h00000000. Separately, 32'h7F800000 then 32'hFF800000 (last) -> 32'hFFC00000.
- Overflow: 32'h7F7FFFFF twice (last) -> 32'h7F800000.
- Subnormal and RNE:
  - 32'h00000001 + 32'h00000001 (last) -> 32'h00000002.
  - 32'h3F800000 + 32'h33800000 (2^-24, tie, last) -> 32'h3F800000 (even).
  - 32'h3F800001 + 32'h33800000 -> 32'h3F800002.
- Reset mid-operation: pull rst_n low during ADD of the second element -> in_ready=1 and out_valid=0 immediately; a new single 32'h40400000 (last) yields 32'h40400000.
